qar_can_tx: RTL

Bit-level CAN 2.0A transmitter that serialises one standard data frame onto `can_tx`. It sits directly downstream of the `qar_can` register block, which supplies the latched TX id, DLC and data words plus a start strobe. The block generates CRC-15 and bit stuffing, performs arbitration against `can_rx`, and checks the ACK slot. It reports completion, arbitration loss or ACK error as one-cycle pulses, which the register block turns into status and IRQ bits.

---
 rtl/qar_can_tx_pkg.sv | 39 +++
 rtl/qar_can_crc15.sv | 34 +++
 rtl/qar_can_tx.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/qar_can_tx_pkg.sv
// Shared CAN constants, field lengths and transmitter state encoding.
// The future RX and bit-timing blocks import the same package.
package qar_can_tx_pkg;

    localparam logic [14:0] CAN_CRC_POLY  = 15'h4599;

    localparam int unsigned CAN_ID_LEN    = 11;
    localparam int unsigned CAN_CTRL_LEN  = 3;   // RTR, IDE, r0
    localparam int unsigned CAN_DLC_LEN   = 4;
    localparam int unsigned CAN_CRC_LEN   = 15;
    localparam int unsigned CAN_EOF_LEN   = 7;
    localparam int unsigned CAN_IFS_LEN   = 3;
    localparam int unsigned CAN_MAX_BYTES = 8;
    localparam int unsigned CAN_STUFF_RUN = 5;

    localparam int unsigned CAN_HDR_LEN   = 1 + CAN_ID_LEN + CAN_CTRL_LEN + CAN_DLC_LEN;
    localparam int unsigned CAN_TAIL_LEN  = 1 + CAN_EOF_LEN + CAN_IFS_LEN;
    localparam int unsigned CAN_POS_W     = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FRAME = 3'd1,
        ST_DELIM = 3'd2,
        ST_ACK   = 3'd3,
        ST_TAIL  = 3'd4
    } can_tx_state_e;

    // One serial CRC-15 step, MSB-first shift.
    function automatic logic [CAN_CRC_LEN-1:0] crc15_step(input logic [CAN_CRC_LEN-1:0] crc,
                                                          input logic                   b);
        logic [CAN_CRC_LEN-1:0] nxt;
        nxt = {crc[CAN_CRC_LEN-2:0], 1'b0};
        if (b ^ crc[CAN_CRC_LEN-1]) begin
            nxt = nxt ^ CAN_CRC_POLY;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/qar_can_crc15.sv
// Serial CRC-15 register; clr has priority over en.
module qar_can_crc15
    import qar_can_tx_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   en,
    input  logic                   bit_in,
    output logic [CAN_CRC_LEN-1:0] crc
);

    logic [CAN_CRC_LEN-1:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = '0;
        end else if (en) begin
            crc_d = crc15_step(crc_q, bit_in);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/qar_can_tx.sv
// CAN 2.0A standard data frame transmitter: bit timing, stuffing, CRC-15,
// arbitration against can_rx and ACK slot check.
module qar_can_tx
    import qar_can_tx_pkg::*;
#(
    parameter int unsigned BRP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [10:0]      id,
    input  logic [3:0]       dlc,
    input  logic [31:0]      data0,
    input  logic [31:0]      data1,
    input  logic [BRP_W-1:0] brp,
    input  logic             can_rx,
    output logic             can_tx,
    output logic             busy,
    output logic             done,
    output logic             arb_lost,
    output logic             ack_err
);

    localparam logic [CAN_POS_W-1:0] POS_ID_END   = CAN_POS_W'(CAN_ID_LEN);
    localparam logic [CAN_POS_W-1:0] POS_RTR      = CAN_POS_W'(CAN_ID_LEN + 1);
    localparam logic [CAN_POS_W-1:0] POS_CTRL_END = CAN_POS_W'(CAN_ID_LEN + CAN_CTRL_LEN);
    localparam logic [CAN_POS_W-1:0] POS_DLC_END  = CAN_POS_W'(CAN_HDR_LEN - 1);
    localparam logic [CAN_POS_W-1:0] POS_DATA     = CAN_POS_W'(CAN_HDR_LEN);
    localparam logic [CAN_POS_W-1:0] POS_TAIL_END = CAN_POS_W'(CAN_TAIL_LEN - 1);

    can_tx_state_e               state_q, state_d;
    logic [BRP_W-1:0]            cnt_q, cnt_d;
    logic [BRP_W-1:0]            brp_q, brp_d;
    logic [CAN_POS_W-1:0]        pos_q, pos_d;
    logic [2:0]                  same_q, same_d;
    logic                        stuff_q, stuff_d;
    logic [CAN_ID_LEN-1:0]       id_q, id_d;
    logic [CAN_DLC_LEN-1:0]      dlc_q, dlc_d;
    logic [63:0]                 data_q, data_d;
    logic                        can_tx_q, can_tx_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        arb_lost_q, arb_lost_d;
    logic                        ack_err_q, ack_err_d;

    logic                        bit_end;
    logic                        sample;
    logic                        arb_act;
    logic                        frame_bit;
    logic [3:0]                  nbytes;
    logic [CAN_POS_W-1:0]        data_end;
    logic [CAN_POS_W-1:0]        last_pos;
    logic [5:0]                  d_off;
    logic [3:0]                  c_off;
    logic                        crc_clr;
    logic                        crc_en;
    logic [CAN_CRC_LEN-1:0]      crc;

    qar_can_crc15 u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (frame_bit),
        .crc    (crc)
    );

    // Frame geometry derived from the latched DLC.
    always_comb begin
        nbytes   = (dlc_q > 4'(CAN_MAX_BYTES)) ? 4'(CAN_MAX_BYTES) : dlc_q;
        data_end = POS_DATA + {nbytes, 3'b000};
        last_pos = data_end + CAN_POS_W'(CAN_CRC_LEN);
        d_off    = 6'(pos_q - POS_DATA);
        c_off    = 4'(pos_q - data_end);
    end

    // Unstuffed bit at position pos_q; SOF (pos 0) is emitted on accept.
    always_comb begin
        frame_bit = 1'b0;
        if (pos_q == '0) begin
            frame_bit = 1'b0;
        end else if (pos_q <= POS_ID_END) begin
            frame_bit = id_q[4'(POS_ID_END - pos_q)];
        end else if (pos_q <= POS_CTRL_END) begin
            frame_bit = 1'b0;
        end else if (pos_q <= POS_DLC_END) begin
            frame_bit = dlc_q[2'(POS_DLC_END - pos_q)];
        end else if (pos_q < data_end) begin
            frame_bit = data_q[{d_off[5:3], ~d_off[2:0]}];
        end else begin
            frame_bit = crc[4'(4'(CAN_CRC_LEN - 1) - c_off)];
        end
    end

    // Arbitration covers SOF..RTR and stuff bits before RTR has been sent.
    always_comb begin
        bit_end = (cnt_q == brp_q);
        sample  = (cnt_q == (brp_q >> 1));
        arb_act = (pos_q <= POS_RTR) || ((pos_q == POS_RTR + CAN_POS_W'(1)) && !stuff_q);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        brp_d      = brp_q;
        pos_d      = pos_q;
        same_d     = same_q;
        stuff_d    = stuff_q;
        id_d       = id_q;
        dlc_d      = dlc_q;
        data_d     = data_q;
        can_tx_d   = can_tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        arb_lost_d = 1'b0;
        ack_err_d  = 1'b0;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;

        if (state_q != ST_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + BRP_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                // The done cycle itself still refuses a new start.
                if (start && !done_q) begin
                    state_d  = ST_FRAME;
                    id_d     = id;
                    dlc_d    = dlc;
                    data_d   = {data1, data0};
                    brp_d    = brp;
                    cnt_d    = '0;
                    pos_d    = CAN_POS_W'(1);
                    same_d   = 3'd1;
                    stuff_d  = 1'b0;
                    can_tx_d = 1'b0;
                    busy_d   = 1'b1;
                    crc_clr  = 1'b1;
                end
            end
            ST_FRAME: begin
                if (sample && arb_act && can_tx_q && !can_rx) begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    can_tx_d   = 1'b1;
                    busy_d     = 1'b0;
                    arb_lost_d = 1'b1;
                end else if (bit_end) begin
                    if (same_q == 3'(CAN_STUFF_RUN)) begin
                        can_tx_d = ~can_tx_q;
                        same_d   = 3'd1;
                        stuff_d  = 1'b1;
                    end else if (pos_q == last_pos) begin
                        state_d  = ST_DELIM;
                        can_tx_d = 1'b1;
                        stuff_d  = 1'b0;
                    end else begin
                        can_tx_d = frame_bit;
                        same_d   = (frame_bit == can_tx_q) ? same_q + 3'd1 : 3'd1;
                        pos_d    = pos_q + CAN_POS_W'(1);
                        stuff_d  = 1'b0;
                        crc_en   = (pos_q < data_end);
                    end
                end
            end
            ST_DELIM: begin
                if (bit_end) begin
                    state_d  = ST_ACK;
                    can_tx_d = 1'b1;
                end
            end
            ST_ACK: begin
                if (sample && can_rx) begin
                    ack_err_d = 1'b1;
                end
                if (bit_end) begin
                    state_d = ST_TAIL;
                    pos_d   = '0;
                end
            end
            ST_TAIL: begin
                if (bit_end) begin
                    if (pos_q == POS_TAIL_END) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        pos_d = pos_q + CAN_POS_W'(1);
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                can_tx_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            brp_q      <= '0;
            pos_q      <= '0;
            same_q     <= '0;
            stuff_q    <= 1'b0;
            id_q       <= '0;
            dlc_q      <= '0;
            data_q     <= '0;
            can_tx_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            arb_lost_q <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            brp_q      <= brp_d;
            pos_q      <= pos_d;
            same_q     <= same_d;
            stuff_q    <= stuff_d;
            id_q       <= id_d;
            dlc_q      <= dlc_d;
            data_q     <= data_d;
            can_tx_q   <= can_tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            arb_lost_q <= arb_lost_d;
            ack_err_q  <= ack_err_d;
        end
    end

    assign can_tx   = can_tx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign arb_lost = arb_lost_q;
    assign ack_err  = ack_err_q;

endmodule
